// File: rtl/s2p_align_ctrl_if.sv
// Byte stream from the deserializer plus lock status and payload toward the sink.
// S2P_ALIGN_STATS_EN adds the ERR_CNT / LOSS_CNT statistics outputs.
interface s2p_align_ctrl_if;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic        DES_RESYNC;
  logic        LOCKED;
  logic [7:0]  DATA_OUT;
  logic        DATA_VALID;
`ifdef S2P_ALIGN_STATS_EN
  logic [15:0] ERR_CNT;
  logic [7:0]  LOSS_CNT;
`endif

  // master: deserializer / payload sink side
  modport master (
    output BYTE_IN, BYTE_VALID,
`ifdef S2P_ALIGN_STATS_EN
    input  ERR_CNT, LOSS_CNT,
`endif
    input  DES_RESYNC, LOCKED, DATA_OUT, DATA_VALID
  );

  // slave: alignment controller side
  modport slave (
    input  BYTE_IN, BYTE_VALID,
`ifdef S2P_ALIGN_STATS_EN
    output ERR_CNT, LOSS_CNT,
`endif
    output DES_RESYNC, LOCKED, DATA_OUT, DATA_VALID
  );
endinterface

// File: rtl/s2p_align_ctrl.sv
// Lane alignment: hunts/confirms/holds COM frame lock, forwards payload only while locked.
// Latency: payload and status registered, 1 CLK after the byte; S2P_ALIGN_STATS_EN adds error/loss counters.
// Backpressure: none; every BYTE_VALID byte is consumed, DES_RESYNC asks the deserializer to re-hunt.
module s2p_align_ctrl #(
  parameter logic [7:0] COM_SYMBOL   = 8'hBC,
  parameter int         FRAME_LEN    = 8,
  parameter int         LOCK_COUNT   = 4,
  parameter int         LOSS_COUNT   = 4,
  parameter int         HUNT_TIMEOUT = 64
) (
  input logic             CLK,
  input logic             RESET,
  s2p_align_ctrl_if.slave bus
);

  localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  localparam int TW = (HUNT_TIMEOUT > 1) ? $clog2(HUNT_TIMEOUT) : 1;

  localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] BAD_MAX  = BW'(LOSS_COUNT);
  localparam logic [TW-1:0] TMR_LAST = TW'(HUNT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [GW-1:0] good_cnt;
  logic [BW-1:0] bad_cnt;
  logic [TW-1:0] hunt_tmr;

  logic          des_resync;
  logic          locked;
  logic          data_vld;
  logic [7:0]    data_dat;

`ifdef S2P_ALIGN_STATS_EN
  logic [15:0]   err_cnt;
  logic [7:0]    loss_cnt;
`endif

  logic          is_com;
  logic          at_bnd;
  logic          good_bnd;
  logic          bad_bnd;
  logic [PW-1:0] pos_inc;
  logic [GW-1:0] good_inc;
  logic [BW-1:0] bad_inc;

  // A bad boundary is either a missing COM where one is due or a COM where none is due.
  always_comb begin
    is_com   = (bus.BYTE_IN == COM_SYMBOL);
    at_bnd   = (pos == '0);
    good_bnd = bus.BYTE_VALID && is_com && at_bnd;
    bad_bnd  = bus.BYTE_VALID && (is_com != at_bnd);
    pos_inc  = (pos == POS_LAST) ? '0 : pos + PW'(1);
    good_inc = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
    bad_inc  = (bad_cnt == BAD_MAX) ? bad_cnt : bad_cnt + BW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_HUNT;
      pos        <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      hunt_tmr   <= '0;
      des_resync <= 1'b0;
      locked     <= 1'b0;
      data_vld   <= 1'b0;
      data_dat   <= '0;
`ifdef S2P_ALIGN_STATS_EN
      err_cnt    <= '0;
      loss_cnt   <= '0;
`endif
    end else begin
      des_resync <= 1'b0;
      data_vld   <= 1'b0;

      case (state)
        ST_HUNT: begin
          // A COM in the timeout cycle takes priority over the resync pulse.
          if (bus.BYTE_VALID && is_com) begin
            hunt_tmr <= '0;
            pos      <= PW'(1);
            good_cnt <= GW'(1);
            if (LOCK_COUNT <= 1) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else begin
              state  <= ST_CHECK;
            end
          end else if (hunt_tmr == TMR_LAST) begin
            hunt_tmr   <= '0;
            des_resync <= 1'b1;
          end else begin
            hunt_tmr   <= hunt_tmr + TW'(1);
          end
        end

        ST_CHECK: begin
          if (good_bnd) begin
            good_cnt <= good_inc;
            pos      <= pos_inc;
            if (good_inc == GOOD_MAX) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end
          end else if (bad_bnd) begin
            state      <= ST_HUNT;
            des_resync <= 1'b1;
            pos        <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
          end else if (bus.BYTE_VALID) begin
            pos <= pos_inc;
          end
        end

        ST_LOCKED: begin
          if (good_bnd) begin
            bad_cnt <= '0;
            pos     <= pos_inc;
          end else if (bad_bnd) begin
`ifdef S2P_ALIGN_STATS_EN
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
`endif
            if (bad_inc == BAD_MAX) begin
              state      <= ST_HUNT;
              locked     <= 1'b0;
              des_resync <= 1'b1;
              pos        <= '0;
              good_cnt   <= '0;
              bad_cnt    <= '0;
`ifdef S2P_ALIGN_STATS_EN
              if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
`endif
            end else begin
              // The offending byte is taken as the new frame start.
              bad_cnt <= bad_inc;
              pos     <= PW'(1);
            end
          end else if (bus.BYTE_VALID) begin
            data_dat <= bus.BYTE_IN;
            data_vld <= 1'b1;
            pos      <= pos_inc;
          end
        end

        default: begin
          state    <= ST_HUNT;
          locked   <= 1'b0;
          pos      <= '0;
          good_cnt <= '0;
          bad_cnt  <= '0;
          hunt_tmr <= '0;
        end
      endcase
    end
  end

  assign bus.DES_RESYNC = des_resync;
  assign bus.LOCKED     = locked;
  assign bus.DATA_OUT   = data_dat;
  assign bus.DATA_VALID = data_vld;
`ifdef S2P_ALIGN_STATS_EN
  assign bus.ERR_CNT    = err_cnt;
  assign bus.LOSS_CNT   = loss_cnt;
`endif

endmodule

// File: tb/tb_s2p_align_ctrl.sv
// Bench for s2p_align_ctrl: directed scenarios then random framed traffic, every cycle compared
// against a frame-rule reference model; stats outputs checked when S2P_ALIGN_STATS_EN is defined.
module tb_s2p_align_ctrl;

  localparam logic [7:0] COM = 8'hBC;
  localparam int FL = 8;
  localparam int LC = 4;
  localparam int LS = 4;
  localparam int HT = 64;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  s2p_align_ctrl_if bus ();

  s2p_align_ctrl #(
    .COM_SYMBOL(COM), .FRAME_LEN(FL), .LOCK_COUNT(LC), .LOSS_COUNT(LS), .HUNT_TIMEOUT(HT)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lock phase, frame phase (byte index mod FL) and run lengths.
  typedef enum int {HUNTING, CONFIRMING, ALIGNED} phase_t;
  phase_t m_phase = HUNTING;
  int m_idx = 0, m_good = 0, m_bad = 0, m_idle = 0;
  int e_resync = 0, e_locked = 0, e_dv = 0, e_dout = 0, e_err = 0, e_loss = 0;

  function automatic void lose_alignment();
    m_phase  = HUNTING;
    e_resync = 1;
    m_idx = 0; m_good = 0; m_bad = 0; m_idle = 0;
  endfunction

  function automatic void model_step(input bit rst, input bit vld, input logic [7:0] b);
    bit com, due;
    e_resync = 0;
    e_dv     = 0;
    if (rst) begin
      m_phase = HUNTING; m_idx = 0; m_good = 0; m_bad = 0; m_idle = 0;
      e_locked = 0; e_dout = 0; e_err = 0; e_loss = 0;
      return;
    end
    com = vld && (b == COM);
    due = (m_idx == 0);
    case (m_phase)
      HUNTING: begin
        if (com) begin
          m_phase = CONFIRMING; m_good = 1; m_idx = 1; m_idle = 0;
        end else if (m_idle == HT - 1) begin
          e_resync = 1; m_idle = 0;
        end else begin
          m_idle++;
        end
      end
      CONFIRMING: if (vld) begin
        if (com && due) begin
          m_good++;
          m_idx = 1;
          if (m_good >= LC) begin m_phase = ALIGNED; e_locked = 1; end
        end else if (com || due) begin
          lose_alignment();
        end else begin
          m_idx = (m_idx + 1) % FL;
        end
      end
      ALIGNED: if (vld) begin
        if (com && due) begin
          m_bad = 0; m_idx = 1;
        end else if (com || due) begin
          m_bad++;
          m_idx = 1;
          if (e_err < 65535) e_err++;
          if (m_bad >= LS) begin
            lose_alignment();
            e_locked = 0;
            if (e_loss < 255) e_loss++;
          end
        end else begin
          e_dv = 1; e_dout = b; m_idx = (m_idx + 1) % FL;
        end
      end
      default: m_phase = HUNTING;
    endcase
  endfunction

  // One CLK: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input bit rst, input bit vld, input logic [7:0] b);
    RESET = rst;
    bus.BYTE_VALID = vld;
    bus.BYTE_IN = b;
    model_step(rst, vld, b);
    @(posedge CLK);
    #1;
    chk("des_resync", {31'd0, bus.DES_RESYNC}, e_resync);
    chk("locked", {31'd0, bus.LOCKED}, e_locked);
    chk("data_valid", {31'd0, bus.DATA_VALID}, e_dv);
    chk("data_out", {24'd0, bus.DATA_OUT}, e_dout);
`ifdef S2P_ALIGN_STATS_EN
    chk("err_cnt", {16'd0, bus.ERR_CNT}, e_err);
    chk("loss_cnt", {24'd0, bus.LOSS_CNT}, e_loss);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, b);
  endtask

  task automatic send_frame(input logic [7:0] head, input int gap);
    send_byte(head, gap);
    for (int i = 1; i < FL; i++) send_byte(8'(i), gap);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    int first_rs, second_rs, dv_seen;
    logic [7:0] b;
    bus.BYTE_IN = 8'h00;
    bus.BYTE_VALID = 1'b0;

    // Reset and free-running hunt timer
    do_reset(3);
    first_rs = 0; second_rs = 0;
    for (int i = 1; i <= 200; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (bus.DES_RESYNC === 1'b1) begin
        if (first_rs == 0) first_rs = i;
        else if (second_rs == 0) second_rs = i;
      end
    end
    chk("first_resync_cycle", first_rs, 64);
    chk("resync_period", second_rs - first_rs, 64);

    // Acquire lock with one byte every 8th CLK, then stream payload
    do_reset(3);
    for (int f = 0; f < 4; f++) send_frame(COM, 7);
    chk("locked_after_4th_com", {31'd0, bus.LOCKED}, 1);
    dv_seen = 0;
    for (int f = 0; f < 3; f++) begin
      send_byte(COM, 7);
      for (int i = 1; i < FL; i++) begin
        send_byte(8'(i), 7);
        if (bus.DATA_VALID === 1'b1 && bus.DATA_OUT == 8'(i)) dv_seen++;
      end
    end
    chk("payload_strobes", dv_seen, 21);

    // Bad boundary during confirmation
    do_reset(3);
    send_frame(COM, 2);
    send_frame(COM, 2);
    send_frame(8'h00, 2);
    send_frame(8'h11, 0);

    // Three bad boundaries while locked, then recovery
    do_reset(3);
    for (int f = 0; f < 5; f++) send_frame(COM, 1);
    for (int f = 0; f < 3; f++) send_frame(8'h00, 1);
    send_frame(COM, 1);
    chk("locked_after_3_bad", {31'd0, bus.LOCKED}, 1);
    for (int f = 0; f < 4; f++) send_frame(8'h5A, 1);
    chk("unlocked_after_4_bad", {31'd0, bus.LOCKED}, 0);

    // COM in the exact timeout cycle, then RESET while locked with a valid byte
    do_reset(3);
    for (int i = 0; i < HT - 1; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, COM);
    chk("com_beats_timeout", {31'd0, bus.DES_RESYNC}, 0);
    for (int i = 1; i < FL; i++) send_byte(8'(i), 0);
    for (int f = 0; f < 4; f++) send_frame(COM, 0);
    step(1'b1, 1'b1, 8'h05);
    step(1'b0, 1'b0, 8'h00);

    // Random framed traffic with corruption, slips, gaps and occasional reset
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 7);
      if ($urandom_range(0, 99) < 2) do_reset(1);
      b = ($urandom_range(0, 99) < 12) ? 8'($urandom_range(0, 255)) : COM;
      send_byte(b, gap);
      for (int i = 1; i < FL; i++) begin
        b = ($urandom_range(0, 99) < 3) ? COM : 8'($urandom_range(0, 255));
        send_byte(b, ($urandom_range(0, 3) == 0) ? gap : 0);
      end
      if ($urandom_range(0, 99) < 4) send_byte(8'($urandom_range(0, 255)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/s2p_align_ctrl.md
Name: s2p_align_ctrl

Overview:
Lane alignment controller placed directly after the serial-to-parallel deserializer. Watches the deserialized byte stream for the COM symbol (0xBC) at fixed frame positions and acquires, confirms, holds and drops byte/frame lock. Forwards payload bytes only while locked. Pulses a resync request so the deserializer re-hunts for the comma when alignment is bad.

Parameters:
COM_SYMBOL, 8'hBC, framing comma byte.
FRAME_LEN, 8, bytes per frame including the COM; legal range 2..256.
LOCK_COUNT, 4, consecutive good COMs (including the first one found) required to declare lock.
LOSS_COUNT, 4, consecutive bad frame boundaries while locked that drop lock.
HUNT_TIMEOUT, 64, CLK cycles in HUNT without a COM before a resync pulse is issued.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
BYTE_IN  in  8  byte from deserializer
BYTE_VALID  in  1  BYTE_IN qualifier; may be sparse, e.g. 1 of every 8 CLKs
DES_RESYNC  out  1  one-cycle pulse; deserializer restarts comma hunt
LOCKED  out  1  frame lock status
DATA_OUT  out  8  payload byte
DATA_VALID  out  1  DATA_OUT qualifier; one-cycle strobe per byte

Behaviour:
- Interface: reset RESET, synchronous, active-high; clock CLK.
- Reset values: DES_RESYNC=0, LOCKED=0, DATA_OUT=0, DATA_VALID=0. State=HUNT; all counters 0.
- Only cycles with BYTE_VALID=1 advance the byte position counter pos (0..FRAME_LEN-1, wraps to 0). A "boundary" is a valid byte arriving with pos==0.
- States:
  - HUNT:
    - Valid byte == COM_SYMBOL: go to CHECK, good_cnt=1, pos for the next byte=1, hunt timer cleared.
    - Otherwise the hunt timer increments every CLK. When it reaches HUNT_TIMEOUT-1: pulse DES_RESYNC and clear the timer.
    - COM and timeout in the same cycle: COM wins and no pulse is issued.
  - CHECK:
    - COM at a boundary: good_cnt++. If good_cnt reaches LOCK_COUNT, go to LOCKED.
    - Non-COM at a boundary, or COM at a non-boundary: go to HUNT and pulse DES_RESYNC.
    - No payload is output in this state.
  - LOCKED:
    - COM at a boundary: bad_cnt=0.
    - Non-COM at a boundary, or COM at a non-boundary: bad_cnt++ and pos resynchronises as if at boundary.
    - bad_cnt reaching LOSS_COUNT: go to HUNT, pulse DES_RESYNC, deassert LOCKED.
    - Non-boundary non-COM bytes are payload.
- LOCKED is registered. It rises the cycle after the LOCK_COUNT-th good COM is sampled and falls the cycle after the LOSS_COUNT-th bad boundary.
- Payload path: DATA_OUT and DATA_VALID are registered with 1-cycle latency from BYTE_VALID. COM bytes are never forwarded. Bad boundary bytes in LOCKED are not forwarded. DATA_OUT holds its last value when DATA_VALID=0.
- DES_RESYNC is exactly one CLK wide. On a DES_RESYNC pulse, pos, good_cnt and bad_cnt clear.
- RESET mid-operation: all state and outputs take their reset values the following cycle regardless of BYTE_VALID.
- Counter widths: sized with clog2 of each parameter. Counters saturate, never wrap.

Optional Feature:
S2P_ALIGN_STATS_EN
- Defined: adds output ERR_CNT[15:0], a saturating count of bad boundaries seen in LOCKED, and output LOSS_CNT[7:0], a saturating count of lock-loss events. Both clear only on RESET.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
1. RESET high 3 cycles, BYTE_VALID=0 → DES_RESYNC, LOCKED and DATA_VALID all 0; first resync pulse at cycle 64 after reset release, repeating every 64 cycles.
2. Stream of frames {BC,01..07}, BYTE_VALID every 8th CLK → LOCKED=1 one cycle after the 4th BC. Then DATA_VALID strobes with 01..07 each frame, each 1 cycle after its BYTE_VALID; BC never appears on DATA_OUT.
3. During CHECK, replace the 3rd BC with 0x00 → single-cycle DES_RESYNC, state HUNT, LOCKED stays 0, no DATA_VALID.
4. While locked, corrupt 3 consecutive boundaries then send a good BC → LOCKED stays 1, bad_cnt clears, ERR_CNT=3 (stats build).
5. While locked, corrupt 4 consecutive boundaries → LOCKED falls 1 cycle after the 4th, DES_RESYNC pulses once, LOSS_CNT=1.
6. BC arriving in the exact cycle the hunt timer hits 63 → no DES_RESYNC, enters CHECK. Separately, RESET asserted while locked with BYTE_VALID=1 → next cycle LOCKED=0 and DATA_VALID=0.
